// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-write bundle for fifo_wr_arbiter.
// The master side is the arbiter; the slave side is the requesters plus the FIFO.
interface fifo_wr_arbiter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  full;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic                  wr_en;
  logic [WIDTH-1:0]      wdata;

  modport master (
    input  req, req_data, full,
    output gnt, ack, wr_en, wdata
  );

  modport slave (
    output req, req_data, full,
    input  gnt, ack, wr_en, wdata
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NREQ requesters.
// Bursts last up to MAX_BURST beats and stall, without timeout, while the FIFO is full.
module fifo_wr_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              res,
  fifo_wr_arbiter_if.master bus
);

  localparam int unsigned OW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_owner_q, last_owner_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;

  logic            beat;
  logic            found;
  logic [OW-1:0]   sel;
  logic [OW-1:0]   idx;

  // Scan starts just after the previous owner, so the last owner has lowest priority.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = OW'((32'(last_owner_q) + k) % NREQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    beat      = (state_q == StBurst) && bus.req[owner_q] && !bus.full;
    bus.wr_en = beat;
    bus.ack   = beat ? (NREQ'(1) << owner_q) : '0;
    bus.wdata = (state_q == StBurst) ? bus.req_data[32'(owner_q) * WIDTH +: WIDTH] : '0;
    bus.gnt   = gnt_q;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    gnt_d        = gnt_q;
    unique case (state_q)
      StIdle: begin
        gnt_d = '0;
        if (found) begin
          owner_d    = sel;
          gnt_d      = NREQ'(1) << sel;
          beat_cnt_d = '0;
          state_d    = StBurst;
        end
      end
      StBurst: begin
        // Dropping req ends the burst even while full is stalling it.
        if (!bus.req[owner_q]) begin
          state_d      = StIdle;
          gnt_d        = '0;
          last_owner_d = owner_q;
        end else if (beat) begin
          if (beat_cnt_q == CW'(MAX_BURST - 1)) begin
            state_d      = StIdle;
            gnt_d        = '0;
            last_owner_d = owner_q;
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      last_owner_q <= OW'(NREQ - 1);
      beat_cnt_q   <= '0;
      gnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      gnt_q        <= gnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: four requesters with scripted data, plus a
// depth-16 FIFO with a slow reader for the end-to-end scenario.
module tb_fifo_wr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic res;
  logic tb_full;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0] dat [4][32];
  int         pos [4];
  int         len [4];
  logic [3:0] last_ack;

  fifo_wr_arbiter_if #(.WIDTH(8), .NREQ(4)) bus ();

  assign bus.full = tb_full;

  fifo_wr_arbiter #(.WIDTH(8), .NREQ(4), .MAX_BURST(4)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  task automatic set_req(input int i, input logic [7:0] base, input int n);
    for (int j = 0; j < 32; j++) dat[i][j] = base + 8'(j);
    len[i] = n;
    pos[i] = 0;
  endtask

  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      bus.req[i]            = (pos[i] < len[i]);
      bus.req_data[i*8 +: 8] = (pos[i] < len[i]) ? dat[i][pos[i]] : 8'h00;
    end
  endtask

  // Requesters advance on the edge that ends an acked cycle.
  task automatic next_cycle();
    last_ack = bus.ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (last_ack[i]) pos[i]++;
    apply();
    #1;
  endtask

  task automatic do_reset();
    res     = 1'b0;
    tb_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      len[i] = 0;
      pos[i] = 0;
    end
    apply();
    repeat (2) @(posedge clk);
    #1;
    res = 1'b1;
  endtask

  task automatic test_reset();
    logic [16:0] obs;
    set_req(1, 8'h11, 4);
    apply();
    #1;
    n_tests++;
    obs = {bus.gnt, bus.wr_en, bus.ack, bus.wdata};
    if (obs !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 00000", obs);
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus.gnt !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_hold_gnt: got %b want 0000", bus.gnt);
    end
    res = 1'b1;
    next_cycle();
    n_tests++;
    obs = {bus.gnt, bus.wr_en, bus.ack, bus.wdata};
    if (obs !== {4'b0010, 1'b1, 4'b0010, 8'h11}) begin
      n_fail++;
      $display("FAIL reset_first_grant: got %h want %h", obs, {4'b0010, 1'b1, 4'b0010, 8'h11});
    end
  endtask

  task automatic test_single();
    logic [3:0]  eg [10];
    logic        ew [10];
    logic [7:0]  ed [10];
    logic [16:0] obs, exp_v;
    eg = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0};
    ew = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    ed = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'hA4, 8'hA5, 8'h00, 8'h00};
    do_reset();
    set_req(2, 8'hA0, 6);
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      obs   = {bus.gnt, bus.wr_en, bus.ack, bus.wr_en ? bus.wdata : 8'h00};
      exp_v = {eg[c], ew[c], ew[c] ? eg[c] : 4'h0, ed[c]};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL single c%0d: got %h want %h", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_round_robin();
    int          b, ph;
    logic [16:0] obs, exp_v;
    logic [3:0]  g;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 8'(i * 16), 8);
    for (int c = 0; c < 25; c++) begin
      next_cycle();
      b  = (c - 1) / 5;
      ph = (c - 1) % 5;
      if (c == 0 || ph == 4) exp_v = 17'h0;
      else begin
        g     = 4'(1 << (b % 4));
        exp_v = {g, 1'b1, g, dat[b % 4][(b / 4) * 4 + ph]};
      end
      obs = {bus.gnt, bus.wr_en, bus.ack, bus.wr_en ? bus.wdata : 8'h00};
      n_tests++;
      if (obs !== exp_v || !$onehot0(bus.gnt)) begin
        n_fail++;
        $display("FAIL round_robin c%0d: got %h want %h", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_full_stall();
    logic [3:0]  eg [12];
    logic        ew [12];
    logic [7:0]  ed [12];
    logic [16:0] obs, exp_v;
    eg = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h2};
    ew = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    ed = '{8'h00, 8'h10, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h12, 8'h13, 8'h00, 8'h14};
    do_reset();
    set_req(1, 8'h10, 6);
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      tb_full = (c >= 3 && c <= 7);
      #1;
      obs   = {bus.gnt, bus.wr_en, bus.ack, bus.wr_en ? bus.wdata : 8'h00};
      exp_v = {eg[c], ew[c], ew[c] ? eg[c] : 4'h0, ed[c]};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL full_stall c%0d: got %h want %h", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_early_release();
    logic [3:0]  eg [6];
    logic        ew [6];
    logic [7:0]  ed [6];
    logic [16:0] obs, exp_v;
    eg = '{4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1};
    ew = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    ed = '{8'h00, 8'h30, 8'h00, 8'h00, 8'h00, 8'h01};
    do_reset();
    set_req(3, 8'h30, 1);
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      obs   = {bus.gnt, bus.wr_en, bus.ack, bus.wr_en ? bus.wdata : 8'h00};
      exp_v = {eg[c], ew[c], ew[c] ? eg[c] : 4'h0, ed[c]};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL early_release c%0d: got %h want %h", c, obs, exp_v);
      end
      if (c == 0) set_req(0, 8'h00, 2);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [16:0] obs, exp_v;
    do_reset();
    set_req(2, 8'h20, 8);
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      obs   = {bus.gnt, bus.wr_en, bus.ack, bus.wr_en ? bus.wdata : 8'h00};
      exp_v = (c == 0) ? 17'h0 : {4'h4, 1'b1, 4'h4, 8'(8'h1F + c)};
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL rst_mid c%0d: got %h want %h", c, obs, exp_v);
      end
    end
    res = 1'b0;
    #1;
    obs = {bus.gnt, bus.wr_en, bus.ack, bus.wdata};
    n_tests++;
    if (obs !== 17'h0) begin
      n_fail++;
      $display("FAIL rst_mid_async: got %h want 00000", obs);
    end
    set_req(0, 8'h00, 4);
    next_cycle();
    res = 1'b1;
    next_cycle();
    obs   = {bus.gnt, bus.wr_en, bus.ack, bus.wdata};
    exp_v = {4'h1, 1'b1, 4'h1, 8'h00};
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL rst_mid_regrant: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_fifo_e2e();
    logic [7:0] fq   [$];
    logic [7:0] expq [$];
    logic [7:0] v;
    int         got, ovf, cyc;
    do_reset();
    set_req(0, 8'h00, 20);
    set_req(1, 8'h40, 20);
    set_req(2, 8'h80, 20);
    for (int b = 0; b < 15; b++)
      for (int k = 0; k < 4; k++) expq.push_back(dat[b % 3][(b / 3) * 4 + k]);
    got = 0;
    ovf = 0;
    cyc = 0;
    while (got < 60 && cyc < 1000) begin
      next_cycle();
      tb_full = (fq.size() >= 16);
      #1;
      // Reader pops once every third edge, before this cycle's write lands.
      if (cyc % 3 == 2 && fq.size() > 0) begin
        v = fq.pop_front();
        n_tests++;
        if (v !== expq[got]) begin
          n_fail++;
          $display("FAIL e2e_beat%0d: got %h want %h", got, v, expq[got]);
        end
        got++;
      end
      if (bus.wr_en) begin
        if (fq.size() >= 16) ovf++;
        else fq.push_back(bus.wdata);
      end
      cyc++;
    end
    n_tests++;
    if (got != 60) begin
      n_fail++;
      $display("FAIL e2e_count: got %0d beats want 60", got);
    end
    n_tests++;
    if (ovf != 0) begin
      n_fail++;
      $display("FAIL e2e_overflow: got %0d writes into full FIFO want 0", ovf);
    end
  endtask

  initial begin
    res      = 1'b0;
    tb_full  = 1'b0;
    last_ack = '0;
    for (int i = 0; i < 4; i++) begin
      len[i] = 0;
      pos[i] = 0;
    end
    apply();
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_early_release();
    test_reset_mid_burst();
    test_fifo_e2e();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin burst arbiter that shares the single write port of the FIFO (`wr_en`/`wdata`/`full`) among `NREQ` requesters in the write-clock domain. It grants one requester at a time for bursts of up to `MAX_BURST` beats. It stalls on `full`, so it never issues a write into a full FIFO. It sits between the requesting agents and the FIFO write side: its `wr_en`/`wdata` outputs drive the FIFO directly, and its `clk` is the FIFO write clock.

## Interface
- `WIDTH`, 8: data width; must equal the FIFO `WIDTH`.
- `NREQ`, 4: number of requesters, 2..16.
- `MAX_BURST`, 4: maximum beats per grant, ≥1.
- `clk` in 1: write-domain clock (same as FIFO `wr_clk`); all state updates on rising edge.
- `res` in 1: reset, asynchronous, active-low.
- `req` in NREQ: `req[i]` high while requester i has a beat presented.
- `req_data` in NREQ*WIDTH: requester i data at `[i*WIDTH +: WIDTH]`.
- `full` in 1: FIFO full flag.
- `gnt` out NREQ: registered, one-hot or zero; current burst owner.
- `ack` out NREQ: combinational; `ack[i]` high in a cycle where requester i's beat is written; requester advances its data on the next edge.
- `wr_en` out 1: combinational FIFO write enable.
- `wdata` out WIDTH: combinational FIFO write data.

## Operation
- State: FSM {IDLE, BURST}, `owner` index, `last_owner` index, `beat_cnt` (width clog2(MAX_BURST+1)).
- Beat condition: `beat = (state==BURST) & req[owner] & ~full`.
  - `wr_en = beat`.
  - `ack = beat ? (1<<owner) : 0`.
  - `wdata = (state==BURST) ? req_data[owner] : 0`.
- IDLE:
  - `gnt=0`.
  - If `|req`, select the first requester with `req` set, scanning `last_owner+1, last_owner+2, …` modulo NREQ.
  - Next edge: `owner` ← selection, `gnt` ← one-hot(selection), `beat_cnt` ← 0, state → BURST.
  - If no `req`, stay in IDLE.
- BURST:
  - Each `beat` increments `beat_cnt`.
  - Exit to IDLE on the next edge when either:
    - `req[owner]==0` (no beat that cycle), or
    - a beat occurs with `beat_cnt==MAX_BURST-1`.
  - On exit: `gnt` ← 0, `last_owner` ← `owner`.
  - `full` high with `req[owner]` high: stall. No beat, `beat_cnt` holds, `gnt` holds. There is no timeout.
- Requests from non-owners are ignored during BURST. A requester must hold `req` and `req_data` stable until acked or until it drops `req`.
- A requester dropping `req` mid-burst ends the burst even while `full` is high.
- Reset (async assert, any state):
  - state=IDLE, `gnt=0`, `beat_cnt=0`, `owner=0`, `last_owner=NREQ-1` (requester 0 has priority first).
  - Hence `wr_en=0`, `ack=0`, `wdata=0`.
  - An in-flight burst is abandoned; no partial write occurs after reset assertion.

## Timing
- Request to first write: `req` seen in IDLE at edge k; `gnt` valid after edge k; first `wr_en` in cycle k+1 if not full.
- Burst throughput: 1 beat/cycle while not full.
- Between bursts there is exactly one IDLE cycle (`gnt=0`). A back-to-back burst to the next requester starts 1 cycle after the previous burst's last beat.
- `full` is sampled combinationally in the same cycle as the write. The FIFO's registered `full` guarantees that no `wr_en` is issued while `full=1`, so FIFO `over_flow` must never assert.
- Reset deassertion is synchronised externally; the first arbitration is on the first edge after `res` rises.

## Test plan
- Single requester:
  - Stimulus: `req[2]` held with data 0xA0..0xA5, not full.
  - Response: `gnt=4'b0100`; beats 0xA0–0xA3 written on 4 consecutive cycles; 1 IDLE cycle; then `gnt` reasserts to 2 and 0xA4, 0xA5 are written.
- Round robin:
  - Stimulus: all four `req` held after reset.
  - Response: grant order 0,1,2,3,0; each burst 4 beats; `gnt` always one-hot or zero.
- Full stall:
  - Stimulus: owner 1 mid-burst at `beat_cnt=2`; `full=1` for 5 cycles.
  - Response: `wr_en=0` and `ack=0` for those 5 cycles; `gnt` holds; after `full` drops, exactly 2 more beats, then exit.
- Early release:
  - Stimulus: owner 3 drops `req` after 1 beat while `req[0]` is pending.
  - Response: IDLE for 1 cycle, then `gnt=4'b0001`.
- Reset mid-burst:
  - Stimulus: `res` low for 1 cycle during owner 2's second beat.
  - Response: `gnt`, `wr_en` and `ack` go 0 immediately (asynchronously); after release, with `req[2]` and `req[0]` both high, requester 0 is granted first.
- End-to-end with FIFO (WIDTH 8, DEPTH 16):
  - Stimulus: 3 requesters push 20 beats each; reader drains slower.
  - Response: all 60 beats arrive in grant order with no loss; FIFO `over_flow` never asserts.
